// File: rtl/anomaly_pkg.sv
// Shared definitions for the anomaly removal frame sequencer and its datapath.
//   state_e  : sequencer states
//   PIX_W    : datapath pixel width
//   BG_PIXEL : value written where the original matches the anomaly frame
package anomaly_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned PIX_W = 8;

  localparam logic [PIX_W-1:0] BG_PIXEL = 8'h00;

endpackage

// File: rtl/anomaly_removal.sv
// Per-pixel anomaly removal datapath.
// Where the original pixel equals the anomaly pixel the background value is
// emitted, otherwise the anomaly pixel passes through. Output is registered.
//   clk, rst   : clock, asynchronous active-high reset
//   orig_pix   : original frame pixel
//   anom_pix   : anomaly frame pixel
//   out_pix    : registered result pixel
module anomaly_removal
  import anomaly_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [anomaly_pkg::PIX_W-1:0]  orig_pix,
  input  logic [anomaly_pkg::PIX_W-1:0]  anom_pix,
  output logic [anomaly_pkg::PIX_W-1:0]  out_pix
);

  logic [anomaly_pkg::PIX_W-1:0] out_pix_d, out_pix_q;

  always_comb begin
    out_pix_d = anom_pix;
    if (orig_pix == anom_pix) out_pix_d = BG_PIXEL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_pix_q <= '0;
    else     out_pix_q <= out_pix_d;
  end

  assign out_pix = out_pix_q;

endmodule

// File: rtl/anomaly_removal_ctrl.sv
// Frame-level sequencer for the anomaly removal unit.
// Scans the original and anomaly frame RAMs in lock-step, pushes each pixel
// pair through anomaly_removal and writes the result to the output RAM at the
// same address. Read-to-write latency is 2 cycles, one pixel per cycle.
//   clk, rst               : clock, asynchronous active-high reset
//   start, abort           : host frame request / cancel
//   rd_en, rd_addr         : shared read port of the two input RAMs
//   orig_rdata, anom_rdata : read data, valid the cycle after rd_en
//   wr_en, wr_addr, wr_data: output RAM write port
//   busy, done             : status (done is a one-cycle pulse)
//   replaced_cnt           : matching-pixel count of the last completed frame
module anomaly_removal_ctrl #(
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  orig_rdata,
  input  logic [PIX_W-1:0]  anom_rdata,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   replaced_cnt
);

  import anomaly_pkg::state_e;
  import anomaly_pkg::IDLE;
  import anomaly_pkg::SCAN;
  import anomaly_pkg::DRAIN;
  import anomaly_pkg::DONE;

  localparam int unsigned       NPIX      = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W:0]   CNT_MAX   = '1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                drain_q, drain_d;
  logic                v1_q, v1_d;     // data-stage valid
  logic [ADDR_W-1:0]   a1_q, a1_d;     // data-stage address
  logic                v2_q, v2_d;     // result-stage valid
  logic [ADDR_W-1:0]   a2_q, a2_d;     // result-stage address
  logic [ADDR_W:0]     cnt_q, cnt_d;   // running match count
  logic [ADDR_W:0]     rep_q, rep_d;   // count of last completed frame

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    v1_d    = (state_q == SCAN);
    a1_d    = addr_q;
    v2_d    = v1_q;
    a2_d    = a1_q;

    if (v1_q && (orig_rdata == anom_rdata) && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = SCAN;
          addr_d  = '0;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        addr_d  = addr_q + 1'b1;
        drain_d = 1'b0;
        if (addr_q == LAST_ADDR) state_d = DRAIN;
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = DONE;
      end
      DONE: begin
        rep_d   = cnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything above; a write already on the port this
    // cycle is unaffected because wr_en/wr_addr are registered.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      v1_d    = 1'b0;
      v2_d    = 1'b0;
      rep_d   = rep_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      drain_q <= 1'b0;
      v1_q    <= 1'b0;
      a1_q    <= '0;
      v2_q    <= 1'b0;
      a2_q    <= '0;
      cnt_q   <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      v1_q    <= v1_d;
      a1_q    <= a1_d;
      v2_q    <= v2_d;
      a2_q    <= a2_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
    end
  end

  anomaly_removal u_anomaly_removal (
    .clk      (clk),
    .rst      (rst),
    .orig_pix (orig_rdata),
    .anom_pix (anom_rdata),
    .out_pix  (wr_data)
  );

  assign rd_en        = (state_q == SCAN);
  assign rd_addr      = addr_q;
  assign wr_en        = v2_q;
  assign wr_addr      = a2_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign replaced_cnt = rep_q;

endmodule

// File: tb/tb_anomaly_removal_ctrl.sv
module tb_anomaly_removal_ctrl;

  localparam int unsigned IMG_W  = 4;
  localparam int unsigned IMG_H  = 2;
  localparam int unsigned NPIX   = IMG_W * IMG_H;
  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        orig_rdata = '0;
  logic [7:0]        anom_rdata = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   replaced_cnt;

  logic [7:0] orig_mem [16];
  logic [7:0] anom_mem [16];
  logic [7:0] exp_pix  [16];

  int n_cmp = 0;
  int n_err = 0;
  int writes = 0;

  anomaly_removal_ctrl #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .PIX_W  (8),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .orig_rdata   (orig_rdata),
    .anom_rdata   (anom_rdata),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .replaced_cnt (replaced_cnt)
  );

  always #5 clk = ~clk;

  // Input RAMs: one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      orig_rdata <= orig_mem[rd_addr];
      anom_rdata <= anom_mem[rd_addr];
    end
  end

  always @(negedge clk) begin
    if (wr_en) writes <= writes + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Hand-written frame images. kind 0: all equal, 1: never equal,
  // 2: equal only at even addresses.
  task automatic load_frame(input int kind);
    for (int i = 0; i < 16; i++) begin
      case (kind)
        0: begin orig_mem[i] = 8'h55 + 8'(i); anom_mem[i] = 8'h55 + 8'(i); end
        1: begin orig_mem[i] = 8'h10 + 8'(i); anom_mem[i] = 8'h20 + 8'(i); end
        default: begin
          if (i % 2 == 0) begin orig_mem[i] = 8'h30 + 8'(i); anom_mem[i] = 8'h30 + 8'(i); end
          else            begin orig_mem[i] = 8'h10 + 8'(i); anom_mem[i] = 8'h40 + 8'(i); end
        end
      endcase
    end
  endtask

  // Runs one frame from a start pulse and checks every cycle 1..N+3.
  // poke_start pulses start again during SCAN, which must be ignored.
  task automatic run_frame(input bit poke_start, input logic [31:0] exp_cnt);
    int w0;
    w0 = writes;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c <= int'(NPIX) + 3; c++) begin
      chk("rd_en", rd_en, (c <= int'(NPIX)));
      if (c <= int'(NPIX)) chk("rd_addr", rd_addr, c - 1);
      chk("wr_en", wr_en, (c >= 3 && c <= int'(NPIX) + 2));
      if (c >= 3 && c <= int'(NPIX) + 2) begin
        chk("wr_addr", wr_addr, c - 3);
        chk("wr_data", wr_data, exp_pix[c-3]);
      end
      chk("done", done, (c == int'(NPIX) + 3));
      chk("busy", busy, 1);
      start = (poke_start && c == 3);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("busy_end", busy, 0);
    chk("done_end", done, 0);
    chk("replaced_cnt", replaced_cnt, exp_cnt);
    chk("write_count", writes - w0, NPIX);
  endtask

  initial begin
    // Expected images (kind 0 all background, kind 1 anomaly, kind 2 mixed)
    // are filled per scenario below.

    // Reset state
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_cnt", replaced_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Scenario 1: all equal -> all background, count 8
    load_frame(0);
    for (int i = 0; i < 16; i++) exp_pix[i] = 8'h00;
    run_frame(1'b0, 8);

    // Scenario 2: never equal -> anomaly passes through, count 0
    load_frame(1);
    for (int i = 0; i < 16; i++) exp_pix[i] = 8'h20 + 8'(i);
    run_frame(1'b0, 0);

    // Scenario 3: equal at even addresses -> count 4
    load_frame(2);
    for (int i = 0; i < 16; i++) exp_pix[i] = (i % 2 == 0) ? 8'h00 : 8'h40 + 8'(i);
    run_frame(1'b0, 4);

    // Abort at cycle 4
    begin
      int w0;
      load_frame(0);
      w0 = writes;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
        chk("abt_rd_en", rd_en, 1);
        chk("abt_wr_en", wr_en, (c >= 3));
        if (c == 4) abort = 1'b1;
        @(posedge clk); #1;
      end
      abort = 1'b0;
      for (int c = 5; c <= 12; c++) begin
        chk("abt_rd_off", rd_en, 0);
        chk("abt_wr_off", wr_en, 0);
        chk("abt_no_done", done, 0);
        chk("abt_busy", busy, 0);
        @(posedge clk); #1;
      end
      chk("abt_cnt_kept", replaced_cnt, 4);
      chk("abt_writes", writes - w0, 2);
    end
    for (int i = 0; i < 16; i++) exp_pix[i] = 8'h00;
    run_frame(1'b0, 8);

    // start+abort together in IDLE is ignored
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_rd_en", rd_en, 0);

    // start during SCAN is ignored: exactly one frame
    begin
      int w0;
      load_frame(1);
      for (int i = 0; i < 16; i++) exp_pix[i] = 8'h20 + 8'(i);
      w0 = writes;
      run_frame(1'b1, 0);
      repeat (12) begin
        @(posedge clk); #1;
        chk("poke_busy", busy, 0);
      end
      chk("poke_writes", writes - w0, NPIX);
    end

    // Reset at cycle 6
    load_frame(0);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_en", rd_en, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd_addr", rd_addr, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_cnt", replaced_cnt, 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 16; i++) exp_pix[i] = 8'h00;
    run_frame(1'b0, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/anomaly_removal_ctrl.md
# anomaly_removal_ctrl

Frame-level sequencer for the per-pixel anomaly removal unit. On a start pulse it scans an original frame buffer and an anomaly frame buffer in lock-step, feeds each pixel pair through the `anomaly_removal` unit, and writes the result to an output frame buffer at the same address. It sits between the three frame RAMs and the host control registers, and reports busy, done and the replaced-pixel count.

## Interface
- `IMG_W`, default 256: frame width in pixels.
- `IMG_H`, default 256: frame height in pixels.
- `PIX_W`, default 8: pixel width; must be 8 to match the datapath.
- `ADDR_W`, default 16: address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle request to process one frame; honoured only in IDLE.
- `abort`  in  1  cancels the frame in progress.
- `rd_en`  out  1  read strobe shared by the original and anomaly RAMs.
- `rd_addr`  out  ADDR_W  read address shared by both input RAMs.
- `orig_rdata`  in  PIX_W  original pixel, valid the cycle after `rd_en`.
- `anom_rdata`  in  PIX_W  anomaly pixel, valid the cycle after `rd_en`.
- `wr_en`  out  1  output RAM write strobe.
- `wr_addr`  out  ADDR_W  output RAM write address.
- `wr_data`  out  PIX_W  modified pixel taken from the datapath.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle pulse when a frame completes without abort.
- `replaced_cnt`  out  ADDR_W+1  number of pixels where original == anomaly in the last completed frame.

## Operation
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE -> SCAN when `start` = 1 and `abort` = 0. `rd_addr` is cleared to 0.
- SCAN issues one read per cycle at addresses 0 .. N-1, where N = IMG_W*IMG_H. After issuing address N-1 the FSM moves to DRAIN.
- DRAIN lasts 2 cycles with `rd_en` = 0, so the pipeline can flush. The FSM then moves to DONE.
- DONE holds `done` = 1 for one cycle, latches the running match count into `replaced_cnt`, then returns to IDLE.
- Pipeline:
  - `orig_rdata` and `anom_rdata` connect directly to the datapath inputs.
  - A 2-stage valid/address shift register tracks each read: rd stage -> data stage -> result stage.
  - `wr_en` is the result-stage valid. `wr_addr` is the result-stage address.
- Match counting:
  - In the data stage, the running counter increments when `orig_rdata` == `anom_rdata` and the stage is valid.
  - The running counter is cleared on the IDLE -> SCAN transition.
  - The counter saturates at 2^(ADDR_W+1)-1.
- `abort` (any non-IDLE state):
  - Next state is IDLE, and all pipeline valids are cleared.
  - `rd_en` and `wr_en` go low from the next cycle.
  - No `done` pulse; `replaced_cnt` keeps its previous value.
  - A write already presented in the same cycle as `abort` still completes.
- `start` while busy is ignored. `start` and `abort` together in IDLE: `abort` wins and the FSM stays in IDLE.
- The datapath's `rst` is tied to `rst`. Its registered output is the only source of `wr_data`.

## Timing
- Reset values:
  - state = IDLE; `rd_en`, `wr_en`, `busy`, `done` = 0.
  - `rd_addr`, `wr_addr` = 0; `wr_data` = 0x00; `replaced_cnt` = 0; pipeline valids = 0.
- With `start` sampled at cycle 0:
  - `rd_en` is high for cycles 1..N, with `rd_addr` = cycle-1.
  - Read data arrives one cycle after each read.
  - `wr_en` is high for cycles 3..N+2, with `wr_addr` = cycle-3.
  - `done` pulses at cycle N+3; `busy` is high for cycles 1..N+3.
- Latency from read to write is 2 cycles. Throughput is 1 pixel/cycle with no bubbles.
- A new `start` is accepted no earlier than cycle N+4, back in IDLE.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronous). No partial `done`.

## Structure
- Package `anomaly_pkg` holds:
  - the state enum (IDLE, SCAN, DRAIN, DONE);
  - `PIX_W` = 8;
  - background constant `BG_PIXEL` = 8'h00.
- One sub-module: `anomaly_removal`, instantiated once as the per-pixel datapath.
- The address counter, pipeline valids and match counter live in the top level.

## Test plan
- IMG_W=4, IMG_H=2, input RAMs all equal, pulse `start` -> 8 writes of 0x00 at addresses 0..7 in cycles 3..10; `done` at cycle 11; `replaced_cnt` = 8.
- Original = 0x10+i, anomaly = 0x20+i -> `wr_data` = 0x20+i at each address i; `replaced_cnt` = 0.
- Match only at even addresses -> 0x00 written at even addresses, anomaly values at odd addresses; `replaced_cnt` = 4.
- `abort` at cycle 4 -> `rd_en` and `wr_en` low from cycle 5; no `done`; `replaced_cnt` unchanged; a following `start` runs a full clean frame.
- `start` pulsed during SCAN, and `start` together with `abort` in IDLE -> both ignored; exactly one frame of 8 writes.
- `rst` asserted at cycle 6 -> all outputs at reset values within the same cycle; FSM in IDLE; next `start` behaves as in the first scenario.
